sprite_mixer: RTL and testbench

Pixel compositing stage between the `pattern` layer generators and the `vga` timing block. Each cycle it takes one 4-bit sprite code per layer for the pixel at (`next_x`, `next_y`), resolves priority and transparency, and maps the winning code through a 16-entry, 24-bit writable palette. It drives the 8-bit R/G/B inputs of `vga`. Palette updates are deferred to vertical blanking so a frame never shows mixed palettes.

---
 rtl/sprite_mixer.sv | 145 ++++++++++++++
 tb/tb_sprite_mixer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mixer.sv
// Two-stage sprite compositor: per-pixel layer priority/transparency resolve,
// then a 16x24-bit palette lookup whose updates are deferred to vertical blanking.
module sprite_mixer #(
   parameter int          NUM_LAYERS = 2,
   parameter logic [23:0] BG_COLOR   = 24'h000000
) (
   input  logic                      CLOCK_25,
   input  logic                      reset,
   input  logic [9:0]                next_x,
   input  logic [9:0]                next_y,
   input  logic [4*NUM_LAYERS-1:0]   sprite_codes,
   input  logic [NUM_LAYERS-1:0]     layer_enable,
   input  logic                      pal_wr_en,
   input  logic [3:0]                pal_wr_addr,
   input  logic [23:0]               pal_wr_data,
   output logic                      pal_wr_ready,
   output logic [7:0]                R_out,
   output logic [7:0]                G_out,
   output logic [7:0]                B_out,
   output logic                      frame_start
);

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] V_ACTIVE = 10'd480;

   function automatic logic [23:0] resetEntry(input logic [3:0] idx);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      r = (idx[0] | idx[3]) ? 8'hFF : 8'h00;
      g = (idx[1] | idx[3]) ? 8'hFF : 8'h00;
      b = idx[2] ? 8'hFF : 8'h00;
      return {r, g, b};
   endfunction

   logic [3:0]  winCode_d, winCode_q;
   logic        bgFlag_d, bgFlag_q;
   logic        activeFlag_d, activeFlag_q;
   logic        originFlag_d, originFlag_q;

   logic [23:0] rgb_d, rgb_q;
   logic        frameStart_q;

   logic [23:0] palette_q [16];
   logic        pending_d, pending_q;
   logic [3:0]  pendAddr_d, pendAddr_q;
   logic [23:0] pendData_d, pendData_q;
   logic        accept;
   logic        commit;

   // Highest-index candidate is overwritten by lower ones, so layer 0 wins ties.
   always_comb begin
      winCode_d = 4'h0;
      bgFlag_d  = 1'b1;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (layer_enable[k] && (sprite_codes[4*k +: 4] != 4'h0)) begin
            winCode_d = sprite_codes[4*k +: 4];
            bgFlag_d  = 1'b0;
         end
      end
      activeFlag_d = (next_x < H_ACTIVE) && (next_y < V_ACTIVE);
      originFlag_d = (next_x == 10'd0) && (next_y == 10'd0);
   end

   always_ff @(posedge CLOCK_25) begin
      if (!reset) begin
         winCode_q    <= 4'h0;
         bgFlag_q     <= 1'b0;
         activeFlag_q <= 1'b0;
         originFlag_q <= 1'b0;
      end else begin
         winCode_q    <= winCode_d;
         bgFlag_q     <= bgFlag_d;
         activeFlag_q <= activeFlag_d;
         originFlag_q <= originFlag_d;
      end
   end

   always_comb begin
      rgb_d = 24'h000000;
      if (activeFlag_q) begin
         if (bgFlag_q) begin
            rgb_d = BG_COLOR;
         end else begin
            rgb_d = palette_q[winCode_q];
         end
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (!reset) begin
         rgb_q        <= 24'h000000;
         frameStart_q <= 1'b0;
      end else begin
         rgb_q        <= rgb_d;
         frameStart_q <= originFlag_q;
      end
   end

   assign R_out       = rgb_q[23:16];
   assign G_out       = rgb_q[15:8];
   assign B_out       = rgb_q[7:0];
   assign frame_start = frameStart_q;

   // One-entry write buffer; it only drains while the incoming row is in blanking.
   assign pal_wr_ready = !pending_q;
   assign accept       = pal_wr_en && pal_wr_ready;
   assign commit       = pending_q && (next_y >= V_ACTIVE);

   always_comb begin
      pending_d  = pending_q;
      pendAddr_d = pendAddr_q;
      pendData_d = pendData_q;
      if (commit) begin
         pending_d = 1'b0;
      end else if (accept) begin
         pending_d  = 1'b1;
         pendAddr_d = pal_wr_addr;
         pendData_d = pal_wr_data;
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (!reset) begin
         pending_q  <= 1'b0;
         pendAddr_q <= 4'h0;
         pendData_q <= 24'h000000;
      end else begin
         pending_q  <= pending_d;
         pendAddr_q <= pendAddr_d;
         pendData_q <= pendData_d;
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            palette_q[i] <= resetEntry(4'(i));
         end
      end else if (commit) begin
         palette_q[pendAddr_q] <= pendData_q;
      end
   end

endmodule

// File: tb/tb_sprite_mixer.sv
// Self-checking bench for sprite_mixer: per-cycle scoreboard of composited
// pixels plus scenario tasks with directed checks.
module tb_sprite_mixer;

   localparam int NUM_LAYERS = 2;

   logic        CLOCK_25 = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  nextX = 10'd0;
   logic [9:0]  nextY = 10'd0;
   logic [7:0]  spriteCodes = 8'h00;
   logic [1:0]  layerEnable = 2'b00;
   logic        palWrEn = 1'b0;
   logic [3:0]  palWrAddr = 4'h0;
   logic [23:0] palWrData = 24'h0;
   logic        palWrReady;
   logic [7:0]  R_out, G_out, B_out;
   logic        frame_start;

   int total = 0;
   int bad = 0;

   logic [24:0] scoreQ [$];
   logic [23:0] modelPal [16];
   logic        modelPending = 1'b0;
   logic [3:0]  modelAddr = 4'h0;
   logic [23:0] modelData = 24'h0;

   sprite_mixer #(.NUM_LAYERS(NUM_LAYERS), .BG_COLOR(24'h000000)) dut (
      .CLOCK_25     (CLOCK_25),
      .reset        (reset),
      .next_x       (nextX),
      .next_y       (nextY),
      .sprite_codes (spriteCodes),
      .layer_enable (layerEnable),
      .pal_wr_en    (palWrEn),
      .pal_wr_addr  (palWrAddr),
      .pal_wr_data  (palWrData),
      .pal_wr_ready (palWrReady),
      .R_out        (R_out),
      .G_out        (G_out),
      .B_out        (B_out),
      .frame_start  (frame_start)
   );

   always #20 CLOCK_25 = ~CLOCK_25;

   function automatic logic [23:0] refEntry(input int i);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      r = (((i % 2) == 1) || (i >= 8)) ? 8'hFF : 8'h00;
      g = ((((i / 2) % 2) == 1) || (i >= 8)) ? 8'hFF : 8'h00;
      b = (((i / 4) % 2) == 1) ? 8'hFF : 8'h00;
      return {r, g, b};
   endfunction

   // Scoreboard: expectation pushed when a pixel is sampled, popped one edge later.
   always @(posedge CLOCK_25) begin
      logic [24:0] expEntry;
      logic [24:0] got;
      logic [3:0]  code;
      logic        isBg;
      logic        isActive;
      logic [23:0] rgb;
      if (reset !== 1'b1) begin
         scoreQ.delete();
         scoreQ.push_back(25'h0);
         modelPending = 1'b0;
         for (int i = 0; i < 16; i++) modelPal[i] = refEntry(i);
         #1;
         total++;
         if ({frame_start, R_out, G_out, B_out} !== 25'h0 || palWrReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL resetOutputs: got fs=%b rgb=%h ready=%b expected fs=0 rgb=000000 ready=1",
                     frame_start, {R_out, G_out, B_out}, palWrReady);
         end
      end else begin
         code = 4'h0;
         isBg = 1'b1;
         for (int k = 0; k < NUM_LAYERS; k++) begin
            if (isBg && layerEnable[k] && spriteCodes[4*k +: 4] != 4'h0) begin
               code = spriteCodes[4*k +: 4];
               isBg = 1'b0;
            end
         end
         isActive = (int'(nextX) < 640) && (int'(nextY) < 480);
         if (!isActive) rgb = 24'h0;
         else if (isBg) rgb = 24'h000000;
         else rgb = modelPal[code];
         scoreQ.push_back({(nextX == 10'd0 && nextY == 10'd0), rgb});
         if (modelPending && int'(nextY) >= 480) begin
            modelPal[modelAddr] = modelData;
            modelPending = 1'b0;
         end else if (!modelPending && palWrEn) begin
            modelPending = 1'b1;
            modelAddr = palWrAddr;
            modelData = palWrData;
         end
         #1;
         if (scoreQ.size() > 1) begin
            expEntry = scoreQ.pop_front();
            got = {frame_start, R_out, G_out, B_out};
            total++;
            if (got !== expEntry) begin
               bad++;
               $display("[TB] FAIL pixelOut: got fs=%b rgb=%h expected fs=%b rgb=%h",
                        got[24], got[23:0], expEntry[24], expEntry[23:0]);
            end
         end
         total++;
         if (palWrReady !== !modelPending) begin
            bad++;
            $display("[TB] FAIL readyModel: got %b expected %b", palWrReady, !modelPending);
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLOCK_25);
   endtask

   task automatic setPix(input int x, input int y, input logic [3:0] c0,
                         input logic [3:0] c1, input logic [1:0] en);
      nextX = 10'(x);
      nextY = 10'(y);
      spriteCodes = {c1, c0};
      layerEnable = en;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      palWrEn = 1'b0;
      setPix(5, 5, 4'd1, 4'd1, 2'b11);
      waitCycles(3);
      total++;
      if ({R_out, G_out, B_out} !== 24'h0 || frame_start !== 1'b0 || palWrReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL test_reset: got rgb=%h fs=%b ready=%b expected 000000 0 1",
                  {R_out, G_out, B_out}, frame_start, palWrReady);
      end
      reset = 1'b1;
      waitCycles(1);
   endtask

   task automatic test_priority();
      setPix(10, 10, 4'd1, 4'd6, 2'b11);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'hFF0000) begin
         bad++; $display("[TB] FAIL prioLayer0: got %h expected FF0000", {R_out, G_out, B_out});
      end
      setPix(10, 10, 4'd0, 4'd8, 2'b11);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'hFFFF00) begin
         bad++; $display("[TB] FAIL transparentL0: got %h expected FFFF00", {R_out, G_out, B_out});
      end
      setPix(10, 10, 4'd0, 4'd8, 2'b01);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'h000000) begin
         bad++; $display("[TB] FAIL background: got %h expected 000000", {R_out, G_out, B_out});
      end
      setPix(10, 10, 4'd1, 4'd6, 2'b10);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'h00FFFF) begin
         bad++; $display("[TB] FAIL disabledL0: got %h expected 00FFFF", {R_out, G_out, B_out});
      end
   endtask

   task automatic test_blank_origin();
      setPix(639, 479, 4'd2, 4'd0, 2'b01);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'h00FF00) begin
         bad++; $display("[TB] FAIL lastActive: got %h expected 00FF00", {R_out, G_out, B_out});
      end
      setPix(700, 10, 4'd5, 4'd5, 2'b11);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'h000000) begin
         bad++; $display("[TB] FAIL hBlank: got %h expected 000000", {R_out, G_out, B_out});
      end
      setPix(0, 0, 4'd1, 4'd0, 2'b11);
      waitCycles(1);
      setPix(1, 0, 4'd1, 4'd0, 2'b11);
      waitCycles(1);
      total++;
      if (frame_start !== 1'b1 || {R_out, G_out, B_out} !== 24'hFF0000) begin
         bad++; $display("[TB] FAIL frameStartHigh: got fs=%b rgb=%h expected 1 FF0000",
                         frame_start, {R_out, G_out, B_out});
      end
      waitCycles(1);
      total++;
      if (frame_start !== 1'b0) begin
         bad++; $display("[TB] FAIL frameStartPulse: got %b expected 0", frame_start);
      end
   endtask

   task automatic test_deferred_write();
      setPix(10, 100, 4'd3, 4'd0, 2'b01);
      palWrEn = 1'b1; palWrAddr = 4'd3; palWrData = 24'h123456;
      waitCycles(1);
      palWrEn = 1'b0;
      total++;
      if (palWrReady !== 1'b0) begin
         bad++; $display("[TB] FAIL readyFallsOnAccept: got %b expected 0", palWrReady);
      end
      palWrEn = 1'b1; palWrData = 24'hABCDEF;
      waitCycles(1);
      palWrEn = 1'b0;
      waitCycles(2);
      total++;
      if (palWrReady !== 1'b0 || {R_out, G_out, B_out} !== 24'hFFFF00) begin
         bad++; $display("[TB] FAIL heldUntilBlank: got ready=%b rgb=%h expected 0 FFFF00",
                         palWrReady, {R_out, G_out, B_out});
      end
      setPix(10, 480, 4'd3, 4'd0, 2'b01);
      waitCycles(1);
      total++;
      if (palWrReady !== 1'b1) begin
         bad++; $display("[TB] FAIL readyAfterCommit: got %b expected 1", palWrReady);
      end
      setPix(10, 490, 4'd3, 4'd0, 2'b01);
      waitCycles(3);
      setPix(0, 0, 4'd3, 4'd0, 2'b01);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'h123456 || frame_start !== 1'b1) begin
         bad++; $display("[TB] FAIL committedEntry: got rgb=%h fs=%b expected 123456 1",
                         {R_out, G_out, B_out}, frame_start);
      end
   endtask

   task automatic test_reset_discard();
      setPix(10, 100, 4'd3, 4'd0, 2'b01);
      palWrEn = 1'b1; palWrAddr = 4'd3; palWrData = 24'h654321;
      waitCycles(1);
      palWrEn = 1'b0;
      reset = 1'b0;
      setPix(10, 480, 4'd3, 4'd0, 2'b01);
      waitCycles(1);
      reset = 1'b1;
      total++;
      if (palWrReady !== 1'b1) begin
         bad++; $display("[TB] FAIL readyAfterReset: got %b expected 1", palWrReady);
      end
      setPix(10, 490, 4'd3, 4'd0, 2'b01);
      waitCycles(2);
      setPix(10, 10, 4'd3, 4'd0, 2'b01);
      waitCycles(2);
      total++;
      if ({R_out, G_out, B_out} !== 24'hFFFF00) begin
         bad++; $display("[TB] FAIL discardedWrite: got %h expected FFFF00", {R_out, G_out, B_out});
      end
   endtask

   task automatic test_blank_write();
      setPix(10, 490, 4'd0, 4'd0, 2'b00);
      palWrEn = 1'b1; palWrAddr = 4'd5; palWrData = 24'h0A0B0C;
      waitCycles(1);
      palWrAddr = 4'd6; palWrData = 24'h0D0E0F;
      total++;
      if (palWrReady !== 1'b0) begin
         bad++; $display("[TB] FAIL blankAcceptLow: got %b expected 0", palWrReady);
      end
      waitCycles(1);
      total++;
      if (palWrReady !== 1'b1) begin
         bad++; $display("[TB] FAIL blankReadyBack: got %b expected 1", palWrReady);
      end
      waitCycles(1);
      palWrEn = 1'b0;
      total++;
      if (palWrReady !== 1'b0) begin
         bad++; $display("[TB] FAIL secondAccept: got %b expected 0", palWrReady);
      end
      waitCycles(1);
      setPix(0, 0, 4'd5, 4'd0, 2'b01);
      waitCycles(1);
      setPix(1, 0, 4'd6, 4'd0, 2'b01);
      waitCycles(1);
      total++;
      if ({R_out, G_out, B_out} !== 24'h0A0B0C) begin
         bad++; $display("[TB] FAIL blankEntry5: got %h expected 0A0B0C", {R_out, G_out, B_out});
      end
      waitCycles(1);
      total++;
      if ({R_out, G_out, B_out} !== 24'h0D0E0F) begin
         bad++; $display("[TB] FAIL blankEntry6: got %h expected 0D0E0F", {R_out, G_out, B_out});
      end
   endtask

   task automatic test_back_to_back();
      int startBad;
      startBad = bad;
      for (int n = 0; n < 400; n++) begin
         setPix($urandom_range(0, 799), $urandom_range(0, 524),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         palWrEn = ($urandom_range(0, 3) == 0);
         palWrAddr = 4'($urandom_range(0, 15));
         palWrData = 24'($urandom);
         waitCycles(1);
      end
      palWrEn = 1'b0;
      waitCycles(3);
      if (bad != startBad) $display("[TB] random stream saw %0d errors", bad - startBad);
   endtask

   initial begin
      test_reset();
      test_priority();
      test_blank_origin();
      test_deferred_write();
      test_reset_discard();
      test_blank_write();
      test_back_to_back();
      waitCycles(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
